// File: rtl/tone_seq_ctrl.sv
// Tone sequencer: steps a small (freq, duration, waveform) table on a prescaled time base and drives the CORDIC PWM inputs.
// Latency: outputs are registered and change one clock after a start, a stop or an entry boundary.
// Backpressure: none; start is a one-cycle request, stop aborts at once, table writes are accepted every cycle. Build option TONE_SEQ_GAP_EN.
module tone_seq_ctrl #(
    parameter int FREQ_W    = 12,
    parameter int ADDR_W    = 3,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 131072,
    parameter int GAP_TICKS = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [FREQ_W-1:0] wr_freq,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic              wr_wave,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic [FREQ_W-1:0] freq,
    output logic              waveform_sel,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_idx
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [ADDR_W:0] LEN_MAX   = (ADDR_W + 1)'(DEPTH);
`ifdef TONE_SEQ_GAP_EN
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef TONE_SEQ_GAP_EN
        S_GAP  = 2'd2,
`endif
        S_PLAY = 2'd1
    } state_e;

    state_e state_q, state_d;

    // Tone table
    logic [FREQ_W-1:0] tbl_freq_q [DEPTH];
    logic [DUR_W-1:0]  tbl_dur_q  [DEPTH];
    logic              tbl_wave_q [DEPTH];

    // Playback datapath
    logic [ADDR_W:0]   len_q,  len_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] idx_q,  idx_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              wave_q, wave_d;
    logic [DUR_W-1:0]  dur_q,  dur_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [DUR_W-1:0]  unit_q, unit_d;
`ifdef TONE_SEQ_GAP_EN
    logic [GW-1:0]     gap_q,  gap_d;
    logic              gap_end;
`endif

    logic              start_ok;
    logic [ADDR_W:0]   len_clamped;
    logic [DUR_W-1:0]  dur_last;
    logic              entry_end;
    logic              is_last;
    logic [ADDR_W-1:0] next_idx;
    logic              load_en;
    logic [ADDR_W-1:0] load_idx;

    // Shared decode: entry boundary, last-entry test and the index that follows
    always_comb begin
        start_ok    = start && (seq_len != '0);
        len_clamped = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
        // dur=0 plays as a single unit, so both 0 and 1 end after unit 0
        dur_last    = (dur_q == '0) ? '0 : dur_q - DUR_W'(1);
        entry_end   = (tick_q == TICK_LAST) && (unit_q == dur_last);
        is_last     = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));
        next_idx    = is_last ? '0 : idx_q + ADDR_W'(1);
`ifdef TONE_SEQ_GAP_EN
        gap_end     = (gap_q == GAP_LAST);
`endif
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: stop dominates, otherwise advance on start / entry end
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (entry_end) begin
                        if (is_last && !loop_q) begin
                            state_d = S_IDLE;
                        end else begin
`ifdef TONE_SEQ_GAP_EN
                            state_d = S_GAP;
`else
                            state_d = S_PLAY;
`endif
                        end
                    end
                end
`ifdef TONE_SEQ_GAP_EN
                S_GAP: begin
                    if (gap_end) state_d = S_PLAY;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs and datapath next values; table fetch happens only on load
    always_comb begin
        len_d    = len_q;
        loop_d   = loop_q;
        idx_d    = idx_q;
        freq_d   = freq_q;
        wave_d   = wave_q;
        dur_d    = dur_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tick_d   = tick_q;
        unit_d   = unit_q;
`ifdef TONE_SEQ_GAP_EN
        gap_d    = gap_q;
`endif
        load_en  = 1'b0;
        load_idx = idx_q;
        if (stop) begin
            freq_d = '0;
            busy_d = 1'b0;
            tick_d = '0;
            unit_d = '0;
`ifdef TONE_SEQ_GAP_EN
            gap_d  = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    freq_d = '0;
                    if (start_ok) begin
                        len_d    = len_clamped;
                        loop_d   = loop;
                        busy_d   = 1'b1;
                        tick_d   = '0;
                        unit_d   = '0;
                        load_en  = 1'b1;
                        load_idx = '0;
                    end
                end
                S_PLAY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (unit_q == dur_last) begin
                            unit_d = '0;
                            if (is_last && !loop_q) begin
                                // one-shot finished: cur_idx and waveform_sel hold
                                freq_d = '0;
                                busy_d = 1'b0;
                                done_d = 1'b1;
                            end else begin
`ifdef TONE_SEQ_GAP_EN
                                // silence first; cur_idx already points at the next entry
                                idx_d  = next_idx;
                                freq_d = '0;
                                gap_d  = '0;
`else
                                load_en  = 1'b1;
                                load_idx = next_idx;
`endif
                            end
                        end else begin
                            unit_d = unit_q + DUR_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`ifdef TONE_SEQ_GAP_EN
                S_GAP: begin
                    if (gap_end) begin
                        load_en  = 1'b1;
                        load_idx = idx_q;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
        if (load_en) begin
            idx_d  = load_idx;
            freq_d = tbl_freq_q[load_idx];
            wave_d = tbl_wave_q[load_idx];
            dur_d  = tbl_dur_q[load_idx];
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_q  <= '0;
            loop_q <= 1'b0;
            idx_q  <= '0;
            freq_q <= '0;
            wave_q <= 1'b0;
            dur_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tick_q <= '0;
            unit_q <= '0;
`ifdef TONE_SEQ_GAP_EN
            gap_q  <= '0;
`endif
        end else begin
            len_q  <= len_d;
            loop_q <= loop_d;
            idx_q  <= idx_d;
            freq_q <= freq_d;
            wave_q <= wave_d;
            dur_q  <= dur_d;
            busy_q <= busy_d;
            done_q <= done_d;
            tick_q <= tick_d;
            unit_q <= unit_d;
`ifdef TONE_SEQ_GAP_EN
            gap_q  <= gap_d;
`endif
        end
    end

    // Table storage: writes land in any state and never touch sequencing
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_freq_q[i] <= '0;
                tbl_dur_q[i]  <= '0;
                tbl_wave_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            tbl_freq_q[wr_addr] <= wr_freq;
            tbl_dur_q[wr_addr]  <= wr_dur;
            tbl_wave_q[wr_addr] <= wr_wave;
        end
    end

    assign freq         = freq_q;
    assign waveform_sel = wave_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cur_idx      = idx_q;

endmodule

// File: tb/tb_tone_seq_ctrl.sv
module tb_tone_seq_ctrl;

    localparam int FREQ_W    = 12;
    localparam int ADDR_W    = 3;
    localparam int DUR_W     = 8;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 3;
    localparam int GAP_N =
`ifdef TONE_SEQ_GAP_EN
        GAP_TICKS;
`else
        0;
`endif

    logic              clock;
    logic              resetn;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [FREQ_W-1:0] wr_freq;
    logic [DUR_W-1:0]  wr_dur;
    logic              wr_wave;
    logic [ADDR_W:0]   seq_len;
    logic              loop;
    logic              start;
    logic              stop;
    logic [FREQ_W-1:0] freq;
    logic              waveform_sel;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_idx;

    tone_seq_ctrl #(
        .FREQ_W(FREQ_W), .ADDR_W(ADDR_W), .DUR_W(DUR_W),
        .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clock(clock), .resetn(resetn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq), .wr_dur(wr_dur), .wr_wave(wr_wave),
        .seq_len(seq_len), .loop(loop), .start(start), .stop(stop),
        .freq(freq), .waveform_sel(waveform_sel), .busy(busy), .done(done), .cur_idx(cur_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One expected-output record held for n consecutive cycles
    typedef struct {
        logic [FREQ_W-1:0] f;
        logic              w;
        logic              cw;   // compare waveform_sel on these cycles
        logic              b;
        logic              d;
        logic [ADDR_W-1:0] idx;
        int                n;
    } seg_t;

    seg_t segs[$];
    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then stable and strobes drop back to 0
    task automatic tick();
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wr(input int a, input int f, input int d, input logic w);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_freq = FREQ_W'(f);
        wr_dur  = DUR_W'(d);
        wr_wave = w;
        tick();
    endtask

    task automatic add(input int f, input logic w, input logic cw, input logic b,
                       input logic d, input int idx, input int n);
        seg_t s;
        s.f = FREQ_W'(f); s.w = w; s.cw = cw; s.b = b; s.d = d;
        s.idx = ADDR_W'(idx); s.n = n;
        segs.push_back(s);
    endtask

    // Silence between entries: waveform holds, index already advanced
    task automatic add_gap(input logic w, input int idx);
        if (GAP_N > 0) add(0, w, 1'b1, 1'b1, 1'b0, idx, GAP_N);
    endtask

    task automatic run(input string name);
        foreach (segs[s]) begin
            for (int k = 0; k < segs[s].n; k++) begin
                chk($sformatf("%s_freq[%0d.%0d]", name, s, k), 32'(freq), 32'(segs[s].f));
                if (segs[s].cw)
                    chk($sformatf("%s_wave[%0d.%0d]", name, s, k), 32'(waveform_sel), 32'(segs[s].w));
                chk($sformatf("%s_busy[%0d.%0d]", name, s, k), 32'(busy), 32'(segs[s].b));
                chk($sformatf("%s_done[%0d.%0d]", name, s, k), 32'(done), 32'(segs[s].d));
                chk($sformatf("%s_idx[%0d.%0d]", name, s, k), 32'(cur_idx), 32'(segs[s].idx));
                tick();
            end
        end
        segs.delete();
    endtask

    task automatic base_table();
        wr(0, 100, 2, 1'b1);
        wr(1, 200, 1, 1'b0);
        wr(2, 300, 3, 1'b1);
    endtask

    task automatic go(input int len, input logic lp);
        seq_len = (ADDR_W + 1)'(len);
        loop    = lp;
        start   = 1'b1;
        tick();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0; wr_wave = 1'b0;
        seq_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_freq", 32'(freq), 0);
        chk("rst_wave", 32'(waveform_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_idx",  32'(cur_idx), 0);
        resetn = 1'b1;
        tick();

        // One-shot playback of the three-entry table
        base_table();
        go(3, 1'b0);
        add(100, 1, 1, 1, 0, 0, 8);  add_gap(1, 1);
        add(200, 0, 1, 1, 0, 1, 4);  add_gap(0, 2);
        add(300, 1, 1, 1, 0, 2, 12);
        add(0, 0, 0, 0, 1, 2, 1);
        add(0, 0, 0, 0, 0, 2, 1);
        run("oneshot");

        // Looped playback: three full passes, never done, then stop mid-pass
        go(3, 1'b1);
        for (int p = 0; p < 3; p++) begin
            add(100, 1, 1, 1, 0, 0, 8);  add_gap(1, 1);
            add(200, 0, 1, 1, 0, 1, 4);  add_gap(0, 2);
            add(300, 1, 1, 1, 0, 2, 12); add_gap(1, 0);
        end
        run("loop");
        chk("loop_wrap_freq", 32'(freq), 100);
        chk("loop_wrap_idx", 32'(cur_idx), 0);
        repeat (3) tick();
        stop = 1'b1;
        tick();
        chk("stop_freq", 32'(freq), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_done", 32'(done), 0);
        tick();
        chk("stop_done_after", 32'(done), 0);
        chk("stop_busy_after", 32'(busy), 0);

        // start with seq_len=0 stays idle
        go(0, 1'b0);
        chk("len0_busy", 32'(busy), 0);
        chk("len0_freq", 32'(freq), 0);

        // start and stop together in idle
        seq_len = 3; loop = 1'b0; start = 1'b1; stop = 1'b1;
        tick();
        chk("startstop_busy", 32'(busy), 0);
        chk("startstop_freq", 32'(freq), 0);
        tick();
        chk("startstop_busy2", 32'(busy), 0);

        // start while busy is ignored
        go(3, 1'b0);
        repeat (8 + GAP_N) tick();
        chk("rebusy_pre_idx", 32'(cur_idx), 1);
        start = 1'b1;
        tick();
        chk("rebusy_idx", 32'(cur_idx), 1);
        chk("rebusy_freq", 32'(freq), 200);
        chk("rebusy_busy", 32'(busy), 1);
        stop = 1'b1;
        tick();
        chk("rebusy_stop_busy", 32'(busy), 0);

        // seq_len=15 clamps to 8 entries; dur=0 plays one unit
        for (int i = 0; i < 8; i++) wr(i, 10 * (i + 1), 0, logic'(i % 2));
        go(15, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add(10 * (i + 1), logic'(i % 2), 1, 1, 0, i, 4);
            if (i < 7) add_gap(logic'(i % 2), i + 1);
        end
        add(0, 0, 0, 0, 1, 7, 1);
        add(0, 0, 0, 0, 0, 7, 1);
        run("clamp");

        // Live write to the playing entry shows up only on the next pass
        base_table();
        go(3, 1'b1);
        add(100, 1, 1, 1, 0, 0, 8); add_gap(1, 1);
        run("live_a");
        wr_en = 1'b1; wr_addr = 1; wr_freq = 555; wr_dur = 1; wr_wave = 1'b0;
        add(200, 0, 1, 1, 0, 1, 4);  add_gap(0, 2);
        add(300, 1, 1, 1, 0, 2, 12); add_gap(1, 0);
        add(100, 1, 1, 1, 0, 0, 8);  add_gap(1, 1);
        add(555, 0, 1, 1, 0, 1, 4);
        run("live_b");
        stop = 1'b1;
        tick();

        // Asynchronous reset mid-play, then play back the cleared table
        go(3, 1'b1);
        repeat (2) tick();
        chk("arst_pre_busy", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("arst_freq", 32'(freq), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_wave", 32'(waveform_sel), 0);
        chk("arst_idx",  32'(cur_idx), 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        tick();
        go(8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add(0, 0, 1, 1, 0, i, 4);
            if (i < 7) add_gap(0, i + 1);
        end
        add(0, 0, 1, 0, 1, 7, 1);
        run("readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_seq_ctrl.md
Name: tone_seq_ctrl

Overview:
- Programmable tone sequencer that drives the frequency word and waveform select of the CORDIC sine/cosine PWM audio path.
- Holds a small table of (freq, duration, waveform) entries and steps through it on a prescaled time base.
- Supports one-shot or looped playback, with start/stop control and a done pulse.
- Sits between the board/control logic and the CORDIC PWM top; its freq and waveform_sel outputs connect directly to that block's inputs.

Parameters:
- FREQ_W, 12, width of the frequency word (matches CORDIC freq input).
- ADDR_W, 3, table address width; DEPTH = 2**ADDR_W entries.
- DUR_W, 8, width of per-entry duration in time units.
- TICK_DIV, 131072, clocks per duration unit.
- GAP_TICKS, 16, silence clocks between entries (used only with TONE_SEQ_GAP_EN).

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write address.
- wr_freq  in  FREQ_W  frequency word to store.
- wr_dur  in  DUR_W  duration in units to store.
- wr_wave  in  1  waveform select to store (1 = sine, 0 = cosine).
- seq_len  in  ADDR_W+1  number of entries to play, 1..DEPTH; values above DEPTH are clamped to DEPTH.
- loop  in  1  1 = wrap to entry 0 after the last entry.
- start  in  1  single-cycle start request.
- stop  in  1  abort request.
- freq  out  FREQ_W  frequency word to the CORDIC.
- waveform_sel  out  1  waveform select to the CORDIC.
- busy  out  1  high while playing.
- done  out  1  single-cycle pulse when a one-shot sequence finishes.
- cur_idx  out  ADDR_W  index of the entry currently playing.

Behaviour:
- Clock and reset: single clock, clock; reset is asynchronous and active-low on resetn.
- Reset values: freq=0, waveform_sel=0, busy=0, done=0, cur_idx=0. All table entries, the tick counter and the unit counter clear to 0. FSM goes to IDLE.
- FSM states: IDLE, PLAY, GAP (GAP exists only with TONE_SEQ_GAP_EN).
- IDLE:
  - start=1, stop=0, seq_len!=0 → latch len=min(seq_len,DEPTH) and loop, load entry 0, go to PLAY.
  - Outputs take effect the next cycle: freq=table[0].freq, waveform_sel=table[0].wave, busy=1, cur_idx=0.
  - Otherwise stay in IDLE with freq=0.
- PLAY timing:
  - tick counter counts 0..TICK_DIV-1; unit counter increments when the tick counter wraps.
  - An entry lasts exactly max(dur,1)*TICK_DIV clocks; dur=0 is treated as 1.
- End of an entry:
  - If idx < len-1 → load idx+1.
  - If idx == len-1 and loop=1 → load idx 0.
  - If idx == len-1 and loop=0 → go to IDLE with done=1 for one cycle, freq=0, busy=0, cur_idx held.
- Loading: an entry is fetched when it is loaded. A write to the currently playing entry does not alter the outputs until that entry is next loaded. Writes are accepted in every state, and wr_en has no effect on sequencing.
- stop: highest priority in every state. The next cycle shows IDLE, freq=0, busy=0, no done pulse, and counters cleared.
- start while busy is ignored. start and stop asserted in the same cycle → stop wins.
- Counters: the unit counter is DUR_W bits and compares against dur-1, so it never wraps. Tick counter width is clog2(TICK_DIV).

Optional Feature:
- Macro: TONE_SEQ_GAP_EN.
- Defined:
  - Between consecutive entries, including the loop wrap, the FSM enters GAP for exactly GAP_TICKS clocks with freq=0.
  - During GAP, waveform_sel holds the previous value, busy=1, and cur_idx already shows the next index.
  - No gap is inserted after the final entry of a one-shot sequence.
  - stop during GAP behaves as in PLAY.
- Undefined: entries play back-to-back; freq switches to the next entry in the same cycle the previous one ends. The GAP state and GAP_TICKS logic are absent.

Test Plan:
- Reset: assert resetn=0 mid-play → outputs immediately 0, busy=0. After release, a table readback by playing gives freq=0 for every entry.
- One-shot (TICK_DIV=4): write {100,2,1},{200,1,0},{300,3,1}, seq_len=3, loop=0, start.
  - freq=100/wave=1 for 8 clocks starting the cycle after start.
  - Then 200/0 for 4 clocks, then 300/1 for 12 clocks.
  - Then done=1 for one cycle, freq=0, busy=0.
- Loop: same table, loop=1 → after 300 for 12 clocks, freq=100 and cur_idx=0; done never asserts over 3 passes. stop mid-pass → freq=0 the next cycle, no done.
- Control corners:
  - start with seq_len=0 → stays IDLE.
  - start while busy → no restart, cur_idx unchanged.
  - start and stop in the same cycle in IDLE → stays IDLE.
  - seq_len=15 → clamps to 8 entries.
- Duration and live write: dur=0 entry plays 4 clocks. A write to entry 1 while entry 1 plays leaves freq unchanged; the new value appears on the next loop pass.
- With TONE_SEQ_GAP_EN, GAP_TICKS=3: one-shot shows freq=0 for 3 clocks between 100→200 and 200→300, and no gap before done.
